// File: rtl/stopwatch_scan.sv
// Tenths-of-second stopwatch with a 4-digit multiplexed 7-segment driver.
// Optional lap-hold display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_scan #(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        gclk,
  input  logic        rst,
  input  logic        clk_1khz,
  input  logic        clk_10hz,
  input  logic        start_stop,
  input  logic        clear,
`ifdef STOPWATCH_LAP_EN
  input  logic        lap,
`endif
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        running,
  output logic [15:0] count_bcd
);

  localparam int unsigned IdxTen  = 0;
  localparam int unsigned IdxScan = 1;
  localparam int unsigned IdxSs   = 2;
  localparam int unsigned IdxClr  = 3;
`ifdef STOPWATCH_LAP_EN
  localparam int unsigned IdxLap  = 4;
  localparam int unsigned NumIn   = 5;
`else
  localparam int unsigned NumIn   = 4;
`endif

  logic [NumIn-1:0]                  in_vec, sync_out, prev_q, tick;
  logic [SYNC_STAGES-1:0][NumIn-1:0] sync_q;

`ifdef STOPWATCH_LAP_EN
  assign in_vec = {lap, clear, start_stop, clk_1khz, clk_10hz};
`else
  assign in_vec = {clear, start_stop, clk_1khz, clk_10hz};
`endif

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign tick     = sync_out & ~prev_q;

  always_ff @(posedge gclk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_vec};
      prev_q <= sync_out;
    end
  end

  logic [15:0] count_q, count_d, disp_d;
  logic        running_q, running_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d, nib;

  // BCD increment with carries rippling through all four digits in one cycle.
  always_comb begin
    count_d   = count_q;
    running_d = running_q ^ tick[IdxSs];
    if (tick[IdxClr]) begin
      count_d = '0;
    end else if (tick[IdxTen] && running_q) begin
      if (count_q[3:0] != 4'd9) begin
        count_d[3:0] = count_q[3:0] + 4'd1;
      end else begin
        count_d[3:0] = 4'd0;
        if (count_q[7:4] != 4'd9) begin
          count_d[7:4] = count_q[7:4] + 4'd1;
        end else begin
          count_d[7:4] = 4'd0;
          if (count_q[11:8] != 4'd5) begin
            count_d[11:8] = count_q[11:8] + 4'd1;
          end else begin
            count_d[11:8] = 4'd0;
            count_d[15:12] = (count_q[15:12] != 4'd9) ? count_q[15:12] + 4'd1 : 4'd0;
          end
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        lap_hold_q, lap_hold_d;
  logic [15:0] lap_q, lap_d;

  always_comb begin
    lap_hold_d = lap_hold_q;
    lap_d      = lap_q;
    if (tick[IdxClr]) begin
      lap_hold_d = 1'b0;
      lap_d      = '0;
    end else if (tick[IdxLap]) begin
      lap_hold_d = ~lap_hold_q;
      if (!lap_hold_q) lap_d = count_q;
    end
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      lap_hold_q <= 1'b0;
      lap_q      <= '0;
    end else begin
      lap_hold_q <= lap_hold_d;
      lap_q      <= lap_d;
    end
  end

  assign disp_d = lap_hold_d ? lap_d : count_d;
`else
  assign disp_d = count_d;
`endif

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // an/seg are built from next-state values so both land on the same edge as the index.
  always_comb begin
    idx_d = tick[IdxScan] ? idx_q + 2'd1 : idx_q;
    unique case (idx_d)
      2'd0:    nib = disp_d[3:0];
      2'd1:    nib = disp_d[7:4];
      2'd2:    nib = disp_d[11:8];
      default: nib = disp_d[15:12];
    endcase
    seg_d = {(idx_d == 2'd1), dec7(nib)} ^ {8{SEG_ACTIVE_LOW}};
    an_d  = (4'b0001 << idx_d) ^ {4{AN_ACTIVE_LOW}};
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      count_q   <= '0;
      running_q <= 1'b0;
      idx_q     <= 2'd0;
      seg_q     <= {1'b0, 7'h3F} ^ {8{SEG_ACTIVE_LOW}};
      an_q      <= 4'b0001 ^ {4{AN_ACTIVE_LOW}};
    end else begin
      count_q   <= count_d;
      running_q <= running_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign running   = running_q;
  assign count_bcd = count_q;

endmodule

// File: tb/tb_stopwatch_scan.sv
// Scoreboard bench for stopwatch_scan: an abstract model (count kept in tenths of a second)
// predicts outputs per input event; a monitor compares one cycle before and at the due cycle.
module tb_stopwatch_scan;

  localparam int Lat = 3;
`ifdef STOPWATCH_LAP_EN
  localparam logic [4:0] MaskAll = 5'h1F;
`else
  localparam logic [4:0] MaskAll = 5'h0F;
`endif

  logic gclk = 1'b0, rst = 1'b1;
  logic clk_1khz = 1'b0, clk_10hz = 1'b0, start_stop = 1'b0, clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
  logic lap = 1'b0;
`endif
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        running;
  logic [15:0] count_bcd;

  stopwatch_scan dut (
    .gclk      (gclk),
    .rst       (rst),
    .clk_1khz  (clk_1khz),
    .clk_10hz  (clk_10hz),
    .start_stop(start_stop),
    .clear     (clear),
`ifdef STOPWATCH_LAP_EN
    .lap       (lap),
`endif
    .seg       (seg),
    .an        (an),
    .running   (running),
    .count_bcd (count_bcd)
  );

  always #5 gclk = ~gclk;

  int cyc = 0;
  always @(posedge gclk) cyc++;

  typedef struct packed {
    logic [15:0] cnt;
    logic        run;
    logic [3:0]  an;
    logic [7:0]  seg;
  } snap_t;

  typedef struct {
    int    due;
    snap_t prev;
    snap_t nxt;
  } item_t;

  item_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: elapsed time in tenths, run flag, scan index, lap hold.
  int m_t = 0, m_lapv = 0, m_idx = 0;
  bit m_run = 1'b0, m_hold = 1'b0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [15:0] to_bcd(input int t);
    int mn, st, su, te;
    mn = t / 600;
    st = (t / 100) % 6;
    su = (t / 10) % 10;
    te = t % 10;
    return {mn[3:0], st[3:0], su[3:0], te[3:0]};
  endfunction

  function automatic snap_t model_snap();
    snap_t      s;
    logic [15:0] d;
    logic [7:0]  raw;
    logic [3:0]  one;
    int          dig;
    s.cnt = to_bcd(m_t);
    s.run = m_run;
    d     = to_bcd(m_hold ? m_lapv : m_t);
    dig   = int'((d >> (4 * m_idx)) & 16'hF);
    raw   = {(m_idx == 1), seg_tab[dig]};
    s.seg = ~raw;
    one   = 4'b0001;
    s.an  = ~(one << m_idx);
    return s;
  endfunction

  task automatic compare(input string nm, input snap_t got, input snap_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got cnt=%h run=%b an=%b seg=%h, expected cnt=%h run=%b an=%b seg=%h",
               nm, cyc, got.cnt, got.run, got.an, got.seg, exp.cnt, exp.run, exp.an, exp.seg);
    end
  endtask

  task automatic check_const(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Monitor: output must still hold the old value one cycle before due, and the new one at due.
  always @(negedge gclk) begin
    if (sb.size() > 0) begin
      if (cyc == sb[0].due - 1) begin
        compare("pre_edge", {count_bcd, running, an, seg}, sb[0].prev);
      end else if (cyc == sb[0].due) begin
        compare("post_edge", {count_bcd, running, an, seg}, sb[0].nxt);
        void'(sb.pop_front());
      end
    end
  end

  task automatic pulse(input logic [4:0] m);
    item_t it;
    @(negedge gclk);
    it.prev = model_snap();
    clk_10hz   = m[0];
    clk_1khz   = m[1];
    start_stop = m[2];
    clear      = m[3];
`ifdef STOPWATCH_LAP_EN
    lap        = m[4];
`endif
    if (m[3]) begin
      m_t = 0;
      m_hold = 1'b0;
      m_lapv = 0;
    end else begin
      if (m[4]) begin
        if (!m_hold) m_lapv = m_t;
        m_hold = !m_hold;
      end
      if (m[0] && m_run) m_t = (m_t + 1) % 6000;
    end
    if (m[2]) m_run = !m_run;
    if (m[1]) m_idx = (m_idx + 1) % 4;
    it.due = cyc + Lat;
    it.nxt = model_snap();
    sb.push_back(it);
    repeat (4) @(negedge gclk);
    clk_10hz = 1'b0; clk_1khz = 1'b0; start_stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    repeat (2) @(negedge gclk);
  endtask

  initial begin
    #1_000_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    item_t it;
    int    r;
    logic [4:0] m;
    repeat (5) @(negedge gclk);
    rst = 1'b0;
    check_const("rst_count", count_bcd, 16'h0000);
    check_const("rst_running", {15'd0, running}, 16'h0000);
    check_const("rst_an", {12'd0, an}, 16'h000E);
    check_const("rst_seg", {8'd0, seg}, 16'h00C0);
    it.due = cyc + 2; it.prev = model_snap(); it.nxt = model_snap();
    sb.push_back(it);
    repeat (3) @(negedge gclk);

    pulse(5'h04);
    repeat (25) pulse(5'h01);
    check_const("count_25", count_bcd, 16'h0025);
    check_const("running_on", {15'd0, running}, 16'h0001);
    repeat (5974) pulse(5'h01);
    check_const("count_9599", count_bcd, 16'h9599);
    pulse(5'h01);
    check_const("wrap_0000", count_bcd, 16'h0000);
    check_const("wrap_running", {15'd0, running}, 16'h0001);
    repeat (600) pulse(5'h01);
    check_const("count_1000", count_bcd, 16'h1000);

    pulse(5'h08);
    repeat (137) pulse(5'h01);
    check_const("count_0137", count_bcd, 16'h0137);
    pulse(5'h09);
    check_const("clear_beats_tick", count_bcd, 16'h0000);
    pulse(5'h04);
    check_const("stopped", {15'd0, running}, 16'h0000);
    repeat (5) pulse(5'h01);
    check_const("frozen", count_bcd, 16'h0000);

    pulse(5'h04);
    repeat (834) pulse(5'h01);
    pulse(5'h04);
    check_const("count_1234", count_bcd, 16'h1234);
    pulse(5'h02);
    check_const("scan1_an", {12'd0, an}, 16'h000D);
    check_const("scan1_seg_dp", {8'd0, seg}, 16'h0030);
    repeat (3) pulse(5'h02);
    check_const("scan0_an", {12'd0, an}, 16'h000E);
    check_const("scan0_seg", {8'd0, seg}, 16'h0099);
    repeat (4) pulse(5'h02);

`ifdef STOPWATCH_LAP_EN
    pulse(5'h08);
    pulse(5'h04);
    repeat (12) pulse(5'h01);
    pulse(5'h10);
    repeat (5) pulse(5'h01);
    check_const("lap_live", count_bcd, 16'h0017);
    check_const("lap_disp_2", {8'd0, seg}, 16'h00A4);
    pulse(5'h10);
    check_const("lap_disp_7", {8'd0, seg}, 16'h00F8);
`endif

    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r < 45)      m = 5'h01;
      else if (r < 78) m = 5'h02;
      else if (r < 86) m = 5'h04;
      else if (r < 92) m = 5'h08;
      else if (r < 96) m = 5'h10;
      else             m = 5'($urandom_range(1, 31));
      m = m & MaskAll;
      if (m == 5'h00) m = 5'h01;
      pulse(m);
    end

    repeat (10) @(negedge gclk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d items left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_scan.md
Name: stopwatch_scan

Overview:
- Consumer of the divided clocks from the clock-generation stage: tenths-of-second stopwatch plus 4-digit multiplexed 7-segment driver.
- clk_10hz and clk_1khz are sampled as data in the gclk domain. They are never used as clocks.
- Rising edges become single-cycle enables: the 10 Hz edge advances the count and the 1 kHz edge advances the digit scan.
- Sits between the clock generator and the board's seven-segment pins/LEDs.

Parameters:
SEG_ACTIVE_LOW, 1, 1: seg outputs low-true (common-anode); 0: high-true
AN_ACTIVE_LOW, 1, 1: digit enables low-true; 0: high-true
SYNC_STAGES, 2, synchronizer depth on clk_10hz, clk_1khz, start_stop, clear (legal 2..4)

Ports:
gclk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
clk_1khz  input  1  scan-rate square wave from clock generator
clk_10hz  input  1  count-rate square wave from clock generator
start_stop  input  1  button, rising edge toggles run state
clear  input  1  button, rising edge zeroes count
seg  output  8  {dp,g,f,e,d,c,b,a} for the currently enabled digit
an  output  4  digit enables, one-hot (polarity per AN_ACTIVE_LOW)
running  output  1  1 while stopwatch counts
count_bcd  output  16  {min, sec_tens, sec_units, tenths}, 4 bits each

Behaviour:
- Reset is synchronous and active-high, and acts on gclk rising edges only.
- Reset clears all synchronizers and edge registers, count_bcd=16'h0000, running=0 and scan index=0.
- After reset, an drives digit 0 enabled; seg shows "0" for digit 0.
- Reset mid-count aborts the count with no residual tick. The edge-detect previous-value regs reset to 0. A clk_10hz input still high after reset therefore produces one tick at the first post-reset edge-detect.
- Input path, per input: SYNC_STAGES flops, then a prev register.
  - tick = sync_out & ~prev, high for exactly one gclk cycle.
  - Latency with SYNC_STAGES=2: an input rising before gclk edge E gives tick high between edges E+1 and E+2. The resulting state change is visible after edge E+2.
- Count, BCD: tenths 0-9, sec_units 0-9, sec_tens 0-5, min 0-9.
  - Increments by one tenth on tick10 only when running=1.
  - Carries ripple in the same cycle. 9:59.9 wraps to 0:00.0 and running stays 1.
- start_stop tick toggles running. The tick10 in the same cycle uses the pre-toggle running value.
- clear tick sets count to 0:00.0 and leaves running unchanged.
  - clear beats a simultaneous tick10: the count becomes 0, not 0:00.1.
  - clear + start_stop in the same cycle: count zeroed and running toggled.
- Scan: a 2-bit index increments on tick1k, wrapping 3 to 0.
  - Index 0 = tenths, 1 = sec_units, 2 = sec_tens, 3 = min.
  - an and seg are registered and change together, one cycle after tick1k. No ghosting cycle with a mismatched digit.
- Segment decode: standard 0-9 patterns (a-g). Codes 10-15 give blank.
  - dp is on only for index 1, separating seconds from tenths.
  - The polarity inversion is applied last.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- With the macro defined, an extra port lap (input, 1) is added with the same synchronizer and edge detect.
  - A lap tick toggles a lap_hold flag. While lap_hold=1, the displayed digits come from a lap register captured at the tick, and counting continues underneath.
  - count_bcd always reflects the live count.
  - clear also clears lap_hold and the lap register.
  - Reset sets lap_hold=0 and lap register=0.
- Without the macro, there is no lap port and the display always shows the live count.

Test Plan:
- Reset hold of 5 cycles with all inputs 0 -> count_bcd=16'h0000, running=0, an=4'b1110, seg=8'hC0 (defaults).
- Pulse start_stop, then 25 clk_10hz rising edges (each high ≥4 gclk) -> running=1, count_bcd=16'h0025. The count changes exactly 3 gclk after each input edge.
- Preload by running to 16'h9599, then 1 more clk_10hz edge -> count_bcd=16'h0000, running=1. Run 600 edges from 0 -> 16'h1000.
- clear and clk_10hz rising in the same gclk cycle while count=16'h0137 -> count_bcd=16'h0000. A second start_stop edge -> running=0, and further clk_10hz edges leave the count unchanged.
- 8 clk_1khz edges with count=16'h1234 -> an cycles 1110, 1101, 1011, 0111 twice. seg decodes 4, 3 (dp on, 8'h30), 2, 1. The an/seg update occurs on the same edge.
- STOPWATCH_LAP_EN: at 16'h0012 pulse lap, then 5 more tenths -> the display shows 0012 while count_bcd=16'h0017. Lap again -> the display shows 0017.
